// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the 7-segment scan sequencer.
// Segment patterns are active-low, ordered gfedcba (bit 0 = a).
package seven_seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam logic [3:0] SCAN_OFF = 4'b1111;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex7seg_decode.sv
// Hex nibble to active-low 7-segment pattern (gfedcba).
// Purely combinational so other display blocks can reuse it.
module hex7seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// 4-digit common-anode scan sequencer with blanking and frame-aligned commit.
// Optional leading-zero suppression: define SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] din,
    input  logic [3:0]  dp_in,
    output logic        load_ack,
    output logic        frame_tick,
    output logic [1:0]  sel,
    output logic [3:0]  scan,
    output logic [6:0]  seg,
    output logic        dp_n
);

    localparam int MAXC = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam bit NO_BLANK = (BLANK_CYCLES == 0);

    state_t         state, ns;
    logic [CW-1:0]  cnt, ncnt;
    logic [1:0]     nsel;
    logic [15:0]    active, shadow, nact;
    logic [3:0]     active_dp, shadow_dp, nact_dp;
    logic           pending, commit, lit;
    logic [3:0]     nib;
    logic [6:0]     nseg;

    always_comb begin
        ns   = state;
        nsel = sel;
        ncnt = cnt + CW'(1);
        if (!en) begin
            ns   = BLANK;
            nsel = 2'd0;
            ncnt = '0;
        end else if (state == BLANK) begin
            if (NO_BLANK || cnt == BLANK_LAST) begin
                ns   = SHOW;
                ncnt = '0;
            end
        end else if (cnt == SHOW_LAST) begin
            nsel = sel + 2'd1;
            ncnt = '0;
            ns   = NO_BLANK ? SHOW : BLANK;
        end
    end

    // Commit window: the frame's last cycle, or any time the scan is parked
    assign commit  = (frame_tick || !en) && (pending || load);
    assign nact    = !commit ? active    : (load ? din   : shadow);
    assign nact_dp = !commit ? active_dp : (load ? dp_in : shadow_dp);
    assign nib     = nact[4*nsel +: 4];

    hex7seg_decode u_dec (
        .hex (nib),
        .seg (nseg)
    );

`ifdef SEVEN_SEG_LZ_BLANK_EN
    logic [3:0] nz;
    logic [3:0] lz;
    assign nz[0] = (nact[3:0]   == 4'h0);
    assign nz[1] = (nact[7:4]   == 4'h0);
    assign nz[2] = (nact[11:8]  == 4'h0);
    assign nz[3] = (nact[15:12] == 4'h0);
    assign lz[3] = nz[3] && !nact_dp[3];
    assign lz[2] = nz[3] && nz[2] && !nact_dp[2];
    assign lz[1] = nz[3] && nz[2] && nz[1] && !nact_dp[1];
    assign lz[0] = nz[0] && 1'b0;
    assign lit   = (ns == SHOW) && !lz[nsel];
`else
    assign lit = (ns == SHOW);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BLANK;
            sel        <= 2'd0;
            cnt        <= '0;
            active     <= '0;
            active_dp  <= '0;
            shadow     <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
            scan       <= SCAN_OFF;
            seg        <= SEG_OFF;
            dp_n       <= 1'b1;
        end else begin
            state      <= ns;
            sel        <= nsel;
            cnt        <= ncnt;
            active     <= nact;
            active_dp  <= nact_dp;
            if (load) begin
                shadow    <= din;
                shadow_dp <= dp_in;
            end
            pending    <= !commit && (pending || load);
            load_ack   <= commit;
            frame_tick <= (ns == SHOW) && (nsel == 2'd3) && (ncnt == SHOW_LAST);
            scan       <= lit ? ~(4'b0001 << nsel) : SCAN_OFF;
            seg        <= lit ? nseg : SEG_OFF;
            dp_n       <= lit ? ~nact_dp[nsel] : 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl (CLK_DIV=4, BLANK_CYCLES=1),
// plus a second instance with BLANK_CYCLES=0.
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst, en, load;
    logic [15:0] din;
    logic [3:0]  dp_in;

    logic        load_ack, frame_tick, dp_n;
    logic [1:0]  sel;
    logic [3:0]  scan;
    logic [6:0]  seg;

    logic        load_ack0, frame_tick0, dp_n0;
    logic [1:0]  sel0;
    logic [3:0]  scan0;
    logic [6:0]  seg0;

    int tests = 0;
    int fails = 0;

    logic [6:0] g_seg [4];
    logic [3:0] g_scan[4];
    logic       g_dpn [4];
    int         g_ack;
    logic       g_ack0;
    logic       g_tick;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(.CLK_DIV(4), .BLANK_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .din(din), .dp_in(dp_in),
        .load_ack(load_ack), .frame_tick(frame_tick),
        .sel(sel), .scan(scan), .seg(seg), .dp_n(dp_n)
    );

    seven_seg_scan_ctrl #(.CLK_DIV(4), .BLANK_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .din(din), .dp_in(dp_in),
        .load_ack(load_ack0), .frame_tick(frame_tick0),
        .sel(sel0), .scan(scan0), .seg(seg0), .dp_n(dp_n0)
    );

    task automatic grab_frame();
        g_ack  = 0;
        g_ack0 = 1'b0;
        g_tick = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            load = 1'b0;
            if (load_ack) g_ack++;
            if (j == 0) g_ack0 = load_ack;
            if (j % 5 == 1) begin
                g_seg[j/5]  = seg;
                g_scan[j/5] = scan;
                g_dpn[j/5]  = dp_n;
            end
            if (j == 19) g_tick = frame_tick;
        end
    endtask

    task automatic wait_tick(output int acks, output bit ok);
        acks = 0;
        ok   = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            load = 1'b0;
            if (load_ack) acks++;
            if (frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0;
        din = 16'h0; dp_in = 4'h0;
        #3;
        tests++;
        if (scan !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1) begin
            fails++;
            $display("FAIL reset_out: got %b/%h/%b want 1111/7f/1", scan, seg, dp_n);
        end
        tests++;
        if (load_ack !== 1'b0 || frame_tick !== 1'b0 || sel !== 2'd0) begin
            fails++;
            $display("FAIL reset_ctl: got %b/%b/%0d want 0/0/0", load_ack, frame_tick, sel);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_scan();
        logic [3:0] es;
        logic [1:0] esel;
        logic [6:0] eseg;
        int p, d;
        rst = 1'b0;
        en  = 1'b1;
        #1;
        tests++;
        if (scan !== 4'hF) begin
            fails++;
            $display("FAIL scan_first: got %b want 1111", scan);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            p    = i % 5;
            d    = i / 5;
            es   = (p == 4) ? 4'hF : (4'hF ^ (4'b0001 << d));
            esel = (p == 4) ? 2'((d + 1) % 4) : 2'(d);
            eseg = (p == 4) ? 7'h7F : 7'h40;
            tests++;
            if (scan !== es || sel !== esel || seg !== eseg) begin
                fails++;
                $display("FAIL scan[%0d]: got %b/%0d/%h want %b/%0d/%h",
                         i, scan, sel, seg, es, esel, eseg);
            end
            tests++;
            if (frame_tick !== (i == 18)) begin
                fails++;
                $display("FAIL tick[%0d]: got %b want %b", i, frame_tick, (i == 18));
            end
        end
    endtask

    task automatic test_load_midframe();
        int  acks = 0;
        bit  ok   = 1'b0;
        repeat (7) @(negedge clk);
        load = 1'b1; din = 16'h12AF; dp_in = 4'b0100;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            load = 1'b0;
            if (load_ack) acks++;
            if (scan != 4'hF) begin
                tests++;
                if (seg !== 7'h40) begin
                    fails++;
                    $display("FAIL mid_old[%0d]: got %h want 40", k, seg);
                end
            end
            if (frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok || acks != 0) begin
            fails++;
            $display("FAIL mid_tick: got tick=%b acks=%0d want 1/0", ok, acks);
        end
        grab_frame();
        tests++;
        if (g_ack0 !== 1'b1 || g_ack != 1) begin
            fails++;
            $display("FAIL mid_ack: got %b/%0d want 1/1", g_ack0, g_ack);
        end
        tests++;
        if (g_seg[0] !== 7'h0E || g_seg[1] !== 7'h08 ||
            g_seg[2] !== 7'h24 || g_seg[3] !== 7'h79) begin
            fails++;
            $display("FAIL mid_seg: got %h %h %h %h want 0e 08 24 79",
                     g_seg[0], g_seg[1], g_seg[2], g_seg[3]);
        end
        tests++;
        if ({g_dpn[3], g_dpn[2], g_dpn[1], g_dpn[0]} !== 4'b1011) begin
            fails++;
            $display("FAIL mid_dp: got %b%b%b%b want 1011",
                     g_dpn[3], g_dpn[2], g_dpn[1], g_dpn[0]);
        end
        tests++;
        if (g_tick !== 1'b1) begin
            fails++;
            $display("FAIL mid_period: got %b want 1", g_tick);
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        dp_in = 4'h0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (load_ack) acks++;
            load = (k == 2 || k == 6);
            if (k == 2) din = 16'h1111;
            if (k == 6) din = 16'h2222;
        end
        tests++;
        if (frame_tick !== 1'b1 || acks != 0) begin
            fails++;
            $display("FAIL b2b_tick: got %b acks=%0d want 1/0", frame_tick, acks);
        end
        grab_frame();
        tests++;
        if (g_seg[0] !== 7'h24 || g_seg[1] !== 7'h24 ||
            g_seg[2] !== 7'h24 || g_seg[3] !== 7'h24) begin
            fails++;
            $display("FAIL b2b_seg: got %h %h %h %h want 24 x4",
                     g_seg[0], g_seg[1], g_seg[2], g_seg[3]);
        end
        tests++;
        if (g_ack != 1 || g_ack0 !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ack: got %0d/%b want 1/1", g_ack, g_ack0);
        end
    endtask

    task automatic test_load_on_tick();
        load = 1'b1;
        din  = 16'h8888;
        grab_frame();
        tests++;
        if (g_seg[0] !== 7'h00 || g_seg[1] !== 7'h00 ||
            g_seg[2] !== 7'h00 || g_seg[3] !== 7'h00) begin
            fails++;
            $display("FAIL tick_load_seg: got %h %h %h %h want 00 x4",
                     g_seg[0], g_seg[1], g_seg[2], g_seg[3]);
        end
        tests++;
        if (g_ack0 !== 1'b1 || g_ack != 1) begin
            fails++;
            $display("FAIL tick_load_ack: got %b/%0d want 1/1", g_ack0, g_ack);
        end
    endtask

    task automatic test_en_drop();
        int acks = 0;
        repeat (12) @(negedge clk);
        tests++;
        if (scan !== 4'b1011) begin
            fails++;
            $display("FAIL en_pre: got %b want 1011", scan);
        end
        en = 1'b0;
        @(negedge clk);
        tests++;
        if (scan !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1 ||
            sel !== 2'd0 || frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL en_off: got %b/%h/%b/%0d/%b want 1111/7f/1/0/0",
                     scan, seg, dp_n, sel, frame_tick);
        end
        load = 1'b1; din = 16'h3333;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            load = 1'b0;
            if (load_ack) acks++;
        end
        tests++;
        if (acks != 1 || scan !== 4'hF) begin
            fails++;
            $display("FAIL en_off_load: got acks=%0d scan=%b want 1/1111", acks, scan);
        end
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                tests++;
                if (scan !== 4'b1110 || seg !== 7'h30 || sel !== 2'd0) begin
                    fails++;
                    $display("FAIL en_rise0: got %b/%h/%0d want 1110/30/0", scan, seg, sel);
                end
            end
            if (k == 4) begin
                tests++;
                if (scan !== 4'hF || sel !== 2'd1) begin
                    fails++;
                    $display("FAIL en_rise4: got %b/%0d want 1111/1", scan, sel);
                end
            end
            if (k == 5) begin
                tests++;
                if (scan !== 4'b1101 || seg !== 7'h30) begin
                    fails++;
                    $display("FAIL en_rise5: got %b/%h want 1101/30", scan, seg);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int acks = 0;
        bit ok   = 1'b0;
        load = 1'b1; din = 16'h5555;
        @(negedge clk);
        load = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (scan !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1 ||
            sel !== 2'd0 || load_ack !== 1'b0 || frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL async_rst: got %b/%h/%b/%0d/%b/%b want 1111/7f/1/0/0/0",
                     scan, seg, dp_n, sel, load_ack, frame_tick);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_tick(acks, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rst_tick: got %b want 1", ok);
        end
        grab_frame();
        tests++;
        if (acks + g_ack != 0 || g_seg[0] !== 7'h40 || g_seg[3] !== 7'h40) begin
            fails++;
            $display("FAIL rst_discard: got acks=%0d seg=%h/%h want 0/40/40",
                     acks + g_ack, g_seg[0], g_seg[3]);
        end
    endtask

    task automatic test_no_blank();
        logic [3:0] es;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            es = 4'hF ^ (4'b0001 << (i / 4));
            tests++;
            if (scan0 !== es || seg0 !== 7'h40) begin
                fails++;
                $display("FAIL nob_scan[%0d]: got %b/%h want %b/40", i, scan0, seg0, es);
            end
            if (i == 15) begin
                tests++;
                if (frame_tick0 !== 1'b1) begin
                    fails++;
                    $display("FAIL nob_tick: got %b want 1", frame_tick0);
                end
            end
        end
    endtask

    task automatic test_lz();
        logic [3:0] es [4];
        logic [6:0] eg [4];
        es[0] = 4'b1110; eg[0] = 7'h40;
        es[1] = 4'b1101; eg[1] = 7'h12;
`ifdef SEVEN_SEG_LZ_BLANK_EN
        es[2] = 4'b1111; eg[2] = 7'h7F;
        es[3] = 4'b1111; eg[3] = 7'h7F;
`else
        es[2] = 4'b1011; eg[2] = 7'h40;
        es[3] = 4'b0111; eg[3] = 7'h40;
`endif
        en = 1'b0; load = 1'b1; din = 16'h0050; dp_in = 4'h0;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k % 5 == 0) begin
                tests++;
                if (scan !== es[k/5] || seg !== eg[k/5]) begin
                    fails++;
                    $display("FAIL lz_d%0d: got %b/%h want %b/%h",
                             k / 5, scan, seg, es[k/5], eg[k/5]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_midframe();
        test_back_to_back();
        test_load_on_tick();
        test_en_drop();
        test_async_reset();
        test_no_blank();
        test_lz();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Sequencer for a 4-digit, common-anode, multiplexed 7-segment display.
- Cycles the digit strobe, inserts anti-ghosting blank time between digits, decodes hex nibbles to segments, and double-buffers display data.
- New data is committed only at frame boundaries, so a frame never mixes old and new digits.
- Sits between the register or user logic that supplies values and the board's scan and segment pins.

Parameters:
- CLK_DIV, 50000, clk cycles each digit is lit (SHOW phase); legal range 1..2^20.
- BLANK_CYCLES, 500, clk cycles all digits are off before each digit lights; 0 skips the BLANK phase.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable; when low, display is dark and the sequencer is parked.
- load  in  1  single-cycle request to latch din/dp_in into the shadow buffer.
- din  in  16  four hex nibbles; din[3:0] is digit 0 (rightmost), din[15:12] is digit 3.
- dp_in  in  4  decimal point per digit, active-high request.
- load_ack  out  1  one-cycle pulse when the shadow buffer is committed to the active buffer.
- frame_tick  out  1  one-cycle pulse at the end of digit 3's SHOW phase.
- sel  out  2  index of the current digit.
- scan  out  4  digit strobes, active-low: digit0 1110, digit1 1101, digit2 1011, digit3 0111; 1111 means dark.
- seg  out  7  segments gfedcba, active-low; seg[0]=a.
- dp_n  out  1  decimal point, active-low.

Behaviour:
- Reset (asynchronous, immediate):
  - State BLANK, sel=0, phase counter 0, active=0x0000, active_dp=0, pending flag clear.
  - Outputs: scan=1111, seg=7'h7F, dp_n=1, load_ack=0, frame_tick=0.
- All outputs are registered and change on the same clk edge as the state/sel they reflect.
- FSM states: BLANK and SHOW.
  - BLANK: scan=1111, seg=7'h7F, dp_n=1. Lasts BLANK_CYCLES cycles, then enters SHOW. If BLANK_CYCLES=0, the FSM goes directly SHOW to SHOW.
  - SHOW: scan = one-hot-low strobe for sel; seg = decode(active nibble[sel]); dp_n = ~active_dp[sel]. Lasts CLK_DIV cycles.
  - At the end of SHOW: sel advances by 1, wrapping 3 to 0, and the FSM returns to BLANK.
- Digit period is BLANK_CYCLES+CLK_DIV cycles; frame period is 4x that.
- frame_tick pulses on the last SHOW cycle of sel=3.
- Shadow load:
  - load=1 copies din/dp_in to the shadow buffer and sets the pending flag.
  - A repeated load before commit overwrites the shadow buffer (last wins).
  - Commit happens on the frame_tick cycle if pending, or if load=1 in that same cycle. In the latter case, din is committed directly.
  - On commit: the pending flag clears and load_ack pulses on the next cycle. Digit 0 of the next frame shows the new data.
- Decoder, hex value to active-low seg: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- en low (sampled each cycle):
  - Next cycle: scan=1111, seg=7'h7F, dp_n=1, state BLANK, sel=0, counter 0, frame_tick=0.
  - Loads are still accepted into the shadow buffer.
  - While en is low, pending data commits immediately; load_ack follows one cycle later.
- en rising: the first digit-0 BLANK phase starts from counter 0.
- Reset mid-frame: abandons the frame and discards any pending data.

Optional Feature:
- Macro: SEVEN_SEG_LZ_BLANK_EN.
- Defined: leading-zero suppression.
  - A digit k in 3..1 is dark in SHOW (scan=1111, seg=7F, dp_n=1) if its nibble and all higher nibbles are 0 and its dp bit is 0.
  - Digit 0 is always shown.
  - Timing and sel are unchanged.
- Undefined: all four digits are always shown.

Decomposition:
- Package seven_seg_pkg: state enum (BLANK, SHOW), the 16-entry segment constant table, SCAN_OFF=4'b1111, SEG_OFF=7'h7F.
- Sub-module hex7seg_decode: combinational, 4-bit in, 7-bit active-low out. Reusable by other display blocks.

Test Plan (CLK_DIV=4, BLANK_CYCLES=1 unless stated):
- Reset then en=1, no load -> scan sequence per 5-cycle digit period: 1111,1110x4,1111,1101x4,1111,1011x4,1111,0111x4; seg=40 during SHOW; frame_tick once every 20 cycles.
- load din=16'h12AF, dp_in=4'b0100 mid-frame -> current frame unchanged; load_ack after frame_tick; next frame: seg 0E,08,24,79 for digits 0..3; dp_n=0 only at sel=2.
- Two loads (16'h1111, then 16'h2222) within one frame -> only 2222 is displayed; exactly one load_ack.
- load coincident with frame_tick, din=16'h8888 -> next frame shows seg=00 on all digits.
- en dropped at sel=2 SHOW -> scan=1111 next cycle; en re-raised -> restart at sel=0 BLANK. Assert rst asynchronously mid-SHOW -> outputs at reset values without waiting for a clk edge.
- BLANK_CYCLES=0 -> no 1111 gaps, digit period 4 cycles. With SEVEN_SEG_LZ_BLANK_EN, din=16'h0050 -> digits 3,2 dark, digit1=12, digit0=40.
